// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM master: opcodes, FSM states and frame sizes.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_CMD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RECV  = 3'd5,
    ST_END   = 3'd6
  } spi_state_e;

  function automatic logic is_read_data(input logic [1:0] op);
    return (op == OP_RD_DATA);
  endfunction

endpackage

// File: rtl/spi_master.sv
// Host-side SPI initiator: frames one {op, data} command per handshake and, for
// read-data commands, captures the 8-bit MISO reply onto the response port.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned GAP      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(READ_LAT - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

  spi_state_e         state_r;
  logic [FRAME_W-1:0] frame_r;
  logic [3:0]         cnt_r;
  logic [DATA_W-2:0]  rx_r;
  logic               rd_op_r;
  logic               ss_n_r;
  logic               mosi_r;
  logic               cmd_ready_r;
  logic               busy_r;
  logic               rsp_valid_r;
  logic [DATA_W-1:0]  rsp_data_r;

  // Frame sequencer; every output is set on the edge that enters its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      frame_r     <= {FRAME_W{1'b0}};
      cnt_r       <= 4'd0;
      rx_r        <= {(DATA_W-1){1'b0}};
      rd_op_r     <= 1'b0;
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            frame_r     <= {cmd_op, cmd_data};
            rd_op_r     <= is_read_data(cmd_op);
            state_r     <= ST_START;
            ss_n_r      <= 1'b0;
            mosi_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ST_START: begin
          state_r <= ST_CMD;
          mosi_r  <= frame_r[FRAME_W-1];
        end
        ST_CMD: begin
          state_r <= ST_SHIFT;
          mosi_r  <= frame_r[FRAME_W-1];
          frame_r <= {frame_r[FRAME_W-2:0], 1'b0};
          cnt_r   <= 4'd0;
        end
        ST_SHIFT: begin
          if (cnt_r == SHIFT_LAST) begin
            cnt_r  <= 4'd0;
            mosi_r <= 1'b0;
            if (rd_op_r) begin
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_END;
              ss_n_r  <= 1'b1;
            end
          end else begin
            cnt_r   <= cnt_r + 4'd1;
            mosi_r  <= frame_r[FRAME_W-1];
            frame_r <= {frame_r[FRAME_W-2:0], 1'b0};
          end
        end
        ST_WAIT: begin
          if (cnt_r == WAIT_LAST) begin
            cnt_r   <= 4'd0;
            state_r <= ST_RECV;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RECV: begin
          rx_r <= {rx_r[DATA_W-3:0], MISO};
          // rsp_data only changes once the whole byte is in, so it never shows a partial capture.
          if (cnt_r == RECV_LAST) begin
            rsp_data_r  <= {rx_r, MISO};
            rsp_valid_r <= 1'b1;
            ss_n_r      <= 1'b1;
            state_r     <= ST_END;
            cnt_r       <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_END: begin
          if (cnt_r == GAP_LAST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          ss_n_r      <= 1'b1;
          mosi_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign SS_n      = ss_n_r;
  assign MOSI      = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a behavioural SPI RAM slave on MOSI/MISO.
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned RL  = 2;
  localparam int unsigned GP  = 1;
  localparam int          TMO = 300;

  typedef struct {
    logic [11:0] bits;
    int          len;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  frame_t     exp_q[$];
  frame_t     obs_q[$];
  logic [7:0] exp_rsp_q[$];
  logic [7:0] obs_rsp_q[$];
  int         gap_q[$];

  spi_master #(.READ_LAT(RL), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: collects frames, inter-frame gaps and responses away from the active edge.
  logic [11:0] mon_bits = 12'h000;
  int mon_len = 0, hi_run = 0, rsp_cyc = 0, rsp_ss_bad = 0, ready_busy_bad = 0;
  bit seen_frame = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      mon_len = 0; mon_bits = 12'h000; seen_frame = 1'b0; hi_run = 0;
    end else begin
      if (!SS_n) begin
        if (mon_len == 0 && seen_frame) gap_q.push_back(hi_run);
        if (mon_len < 12) mon_bits = {mon_bits[10:0], MOSI};
        mon_len++;
      end else begin
        if (mon_len > 0) begin
          f.bits = mon_bits; f.len = mon_len; obs_q.push_back(f);
          mon_len = 0; seen_frame = 1'b1; hi_run = 0;
        end
        hi_run++;
      end
      if (rsp_valid) begin
        obs_rsp_q.push_back(rsp_data);
        rsp_cyc = cyc;
        if (SS_n !== 1'b1) rsp_ss_bad++;
      end
      if (cmd_ready === busy) ready_busy_bad++;
    end
  end

  // Behavioural single-port-RAM slave; drives MISO on the falling edge ahead of each sample.
  logic [11:0] sl_bits = 12'h000;
  logic [7:0]  sl_mem [256];
  logic [7:0]  sl_addr = 8'h00, sl_rd_addr = 8'h00, sl_byte = 8'h00;
  logic [7:0]  miso_fixed = 8'h00;
  bit          miso_fixed_en = 1'b0;
  bit          sl_rd = 1'b0;
  logic        miso_next = 1'b0;
  int          sl_n = 0, sl_t = 0;
  always @(posedge clk) begin
    if (!rst_n || SS_n) begin
      sl_n = 0; sl_rd = 1'b0; miso_next = 1'b0;
    end else if (sl_n < 12) begin
      sl_bits = {sl_bits[10:0], MOSI};
      sl_n++;
      if (sl_n == 12) begin
        case (sl_bits[9:8])
          OP_WR_ADDR: sl_addr = sl_bits[7:0];
          OP_WR_DATA: sl_mem[sl_addr] = sl_bits[7:0];
          OP_RD_ADDR: sl_rd_addr = sl_bits[7:0];
          default: begin
            sl_rd = 1'b1; sl_t = 0;
            sl_byte = miso_fixed_en ? miso_fixed : sl_mem[sl_rd_addr];
          end
        endcase
      end
    end else if (sl_rd) begin
      sl_t++;
      if (sl_t >= int'(RL) && sl_t <= int'(RL) + 7) miso_next = sl_byte[7 - (sl_t - int'(RL))];
      else miso_next = 1'b0;
    end
  end
  always @(negedge clk) MISO = miso_next;

  task automatic drive_cmd(input logic [1:0] op, input logic [7:0] data, input bit hold, output int k);
    frame_t e;
    int n = 0;
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0; k = cyc;
    end else begin
      @(posedge clk); #1;
      k = cyc;
      e.bits = {1'b0, op[1], op, data};
      e.len  = (op == OP_RD_DATA) ? 20 + int'(RL) : 12;
      exp_q.push_back(e);
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int nf, input int nr);
    int n = 0;
    while ((obs_q.size() < nf || obs_rsp_q.size() < nr) && n < TMO) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (SS_n !== 1'b1)      begin failures++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
    checks++; if (MOSI !== 1'b0)      begin failures++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
  endtask

  task automatic test_write_frame();
    frame_t o, e;
    int k;
    drive_cmd(OP_WR_ADDR, 8'hA5, 1'b0, k);
    wait_frames(1, 0);
    checks++;
    if (obs_q.size() < 1 || exp_q.size() < 1) begin
      failures++; $display("FAIL write_frame_seen: got %0d frames want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.bits !== e.bits) begin failures++; $display("FAIL write_mosi: got %b want %b", o.bits, e.bits); end
      checks++; if (o.len != e.len) begin failures++; $display("FAIL write_ss_len: got %0d want %0d", o.len, e.len); end
    end
    checks++; if (obs_rsp_q.size() != 0) begin failures++; $display("FAIL write_no_rsp: got %0d rsp want 0", obs_rsp_q.size()); end
  endtask

  task automatic test_ram_sequence();
    frame_t o, e;
    logic [7:0] r;
    int k;
    drive_cmd(OP_WR_ADDR, 8'h12, 1'b0, k);
    drive_cmd(OP_WR_DATA, 8'h3C, 1'b0, k);
    drive_cmd(OP_RD_ADDR, 8'h12, 1'b0, k);
    drive_cmd(OP_RD_DATA, 8'h00, 1'b0, k);
    exp_rsp_q.push_back(8'h3C);
    wait_frames(4, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
        failures++; $display("FAIL ram_frame_seen: frame %0d missing", i);
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o.bits !== e.bits) begin failures++; $display("FAIL ram_mosi: frame %0d got %b want %b", i, o.bits, e.bits); end
        checks++; if (o.len != e.len) begin failures++; $display("FAIL ram_ss_len: frame %0d got %0d want %0d", i, o.len, e.len); end
      end
    end
    checks++;
    if (obs_rsp_q.size() != 1) begin
      failures++; $display("FAIL ram_rsp_count: got %0d want 1", obs_rsp_q.size());
    end else begin
      r = obs_rsp_q.pop_front();
      checks++; if (r !== exp_rsp_q[0]) begin failures++; $display("FAIL ram_rsp_data: got %h want %h", r, exp_rsp_q[0]); end
    end
    obs_rsp_q.delete(); exp_rsp_q.delete();
  endtask

  task automatic test_read_fixed();
    frame_t o, e;
    logic [7:0] r;
    int k;
    miso_fixed_en = 1'b1; miso_fixed = 8'hC3; rsp_ss_bad = 0;
    drive_cmd(OP_RD_DATA, 8'hFF, 1'b0, k);
    exp_rsp_q.push_back(8'hC3);
    wait_frames(1, 1);
    checks++;
    if (obs_rsp_q.size() != 1) begin
      failures++; $display("FAIL rd_rsp_count: got %0d want 1", obs_rsp_q.size());
    end else begin
      r = obs_rsp_q.pop_front();
      checks++; if (r !== exp_rsp_q[0]) begin failures++; $display("FAIL rd_rsp_data: got %h want %h", r, exp_rsp_q[0]); end
      checks++; if (rsp_cyc - k != 20 + int'(RL)) begin failures++; $display("FAIL rd_rsp_time: got k+%0d want k+%0d", rsp_cyc - k, 20 + int'(RL)); end
    end
    checks++; if (rsp_ss_bad != 0) begin failures++; $display("FAIL rd_rsp_ss_n: got %0d pulses with SS_n low want 0", rsp_ss_bad); end
    checks++;
    if (obs_q.size() < 1 || exp_q.size() < 1) begin
      failures++; $display("FAIL rd_frame_seen: got %0d frames want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.len != e.len) begin failures++; $display("FAIL rd_ss_len: got %0d want %0d", o.len, e.len); end
      checks++; if (o.bits !== e.bits) begin failures++; $display("FAIL rd_mosi: got %b want %b", o.bits, e.bits); end
    end
    miso_fixed_en = 1'b0; obs_rsp_q.delete(); exp_rsp_q.delete();
  endtask

  task automatic test_back_to_back();
    frame_t o, e;
    int k0, k1, k2;
    gap_q.delete(); ready_busy_bad = 0;
    drive_cmd(OP_WR_ADDR, 8'h11, 1'b1, k0);
    drive_cmd(OP_WR_DATA, 8'h22, 1'b1, k1);
    drive_cmd(OP_RD_ADDR, 8'h33, 1'b1, k2);
    cmd_valid = 1'b0;
    wait_frames(3, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q.size() < 1 || exp_q.size() < 1) begin
        failures++; $display("FAIL b2b_frame_seen: frame %0d missing", i);
      end else begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o.bits !== e.bits) begin failures++; $display("FAIL b2b_mosi: frame %0d got %b want %b", i, o.bits, e.bits); end
      end
    end
    checks++; if (k1 - k0 != 13 + int'(GP)) begin failures++; $display("FAIL b2b_accept_spacing1: got %0d want %0d", k1 - k0, 13 + int'(GP)); end
    checks++; if (k2 - k1 != 13 + int'(GP)) begin failures++; $display("FAIL b2b_accept_spacing2: got %0d want %0d", k2 - k1, 13 + int'(GP)); end
    checks++;
    if (gap_q.size() < 3) begin
      failures++; $display("FAIL b2b_gap_count: got %0d want 3", gap_q.size());
    end else begin
      if (gap_q[1] != int'(GP) + 1) begin failures++; $display("FAIL b2b_gap1: got %0d want %0d", gap_q[1], GP + 1); end
      checks++; if (gap_q[2] != int'(GP) + 1) begin failures++; $display("FAIL b2b_gap2: got %0d want %0d", gap_q[2], GP + 1); end
    end
    checks++; if (ready_busy_bad != 0) begin failures++; $display("FAIL b2b_ready_vs_busy: got %0d bad cycles want 0", ready_busy_bad); end
  endtask

  task automatic test_reset_midframe();
    frame_t o, e;
    int k, target;
    obs_rsp_q.delete(); obs_q.delete(); exp_q.delete();
    miso_fixed_en = 1'b1; miso_fixed = 8'hFF;
    drive_cmd(OP_RD_DATA, 8'h00, 1'b0, k);
    target = k + 16 + int'(RL);
    while (cyc < target) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (SS_n !== 1'b1)      begin failures++; $display("FAIL midrst_ss_n: got %b want 1", SS_n); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    miso_fixed_en = 1'b0;
    repeat (30) @(posedge clk);
    checks++; if (obs_rsp_q.size() != 0) begin failures++; $display("FAIL midrst_no_rsp: got %0d rsp want 0", obs_rsp_q.size()); end
    drive_cmd(OP_WR_DATA, 8'h5A, 1'b0, k);
    wait_frames(1, 0);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() < 1) begin
      failures++; $display("FAIL midrst_frame_count: got %0d frames want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.bits !== e.bits) begin failures++; $display("FAIL midrst_mosi: got %b want %b", o.bits, e.bits); end
      checks++; if (o.len != e.len) begin failures++; $display("FAIL midrst_ss_len: got %0d want %0d", o.len, e.len); end
    end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_ram_sequence();
    test_read_fixed();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
